// File: rtl/n1_pkg.sv
`default_nettype none
// ============================================================================
// n1_pkg: shared loader state encodings, error codes and frame defaults. Rev 1.0
// ============================================================================
package n1_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_CSUM  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/n1_prog_loader.sv
`default_nettype none
// ============================================================================
// n1_prog_loader: framed byte-stream loader writing a checksummed image into core RAM. Rev 1.0
// ============================================================================
module n1_prog_loader
    import n1_pkg::*;
#(
    parameter int          RAM_BYTES      = 128,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int          TIMEOUT_CYCLES = 1024,
    localparam int         ADDR_W         = $clog2(RAM_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic              ram_ready,
    output logic              core_run,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int                TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [2:0]        state;
    logic [7:0]        count;
    logic [7:0]        sum;
    logic [ADDR_W-1:0] addr;
    logic [TO_W-1:0]   tcnt;

    logic       accept;
    logic       is_sync;
    logic       len_ok;
    logic       in_frame;
    logic [7:0] sum_chk;

    // ram_we doubles as the write-buffer occupancy flag
    assign in_ready = !ram_we || ram_ready;
    assign accept   = in_valid && in_ready;
    assign is_sync  = (in_data == SYNC_BYTE);
    assign len_ok   = (in_data != 8'd0) && (int'(in_data) <= RAM_BYTES);
    assign sum_chk  = sum + in_data;
    assign in_frame = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
    assign core_run = (state == ST_DONE) && !ram_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= 8'd0;
            sum       <= 8'd0;
            addr      <= '0;
            tcnt      <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 8'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            done <= 1'b0;
            if (ram_we && ram_ready) begin
                ram_we <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept && is_sync) begin
                        state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        if (len_ok) begin
                            count <= in_data;
                            addr  <= '0;
                            sum   <= 8'd0;
                            state <= ST_DATA;
                        end else begin
                            state    <= ST_ERROR;
                            err      <= 1'b1;
                            err_code <= ERR_LEN;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        // Later assignment wins over the drain above: drain and reload in one cycle
                        ram_we    <= 1'b1;
                        ram_addr  <= addr;
                        ram_wdata <= in_data;
                        addr      <= addr + ADDR_ONE;
                        sum       <= sum_chk;
                        count     <= count - 8'd1;
                        if (count == 8'd1) begin
                            state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        if (sum_chk == 8'd0) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            err      <= 1'b0;
                            err_code <= ERR_NONE;
                        end else begin
                            state    <= ST_ERROR;
                            err      <= 1'b1;
                            err_code <= ERR_CSUM;
                        end
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (accept && is_sync) begin
                        state    <= ST_LEN;
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Stalled-by-backpressure cycles neither count nor clear the idle timer
            if (!in_frame || accept) begin
                tcnt <= '0;
            end else if (!in_valid) begin
                if (tcnt == TO_LAST) begin
                    tcnt     <= '0;
                    state    <= ST_ERROR;
                    err      <= 1'b1;
                    err_code <= ERR_TIMEOUT;
                end else begin
                    tcnt <= tcnt + TO_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_n1_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_n1_prog_loader: directed and randomized frame checks against a frame-level model. Rev 1.0
// ============================================================================
module tb_n1_prog_loader;

    localparam int         RAM_BYTES = 128;
    localparam int         TIMEOUT   = 1024;
    localparam int         AW        = 7;
    localparam logic [7:0] SYNC      = 8'hA5;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          ram_ready = 1'b1;
    logic          core_run;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] log_q[$];
    int          log_base  = 0;
    int          done_cnt  = 0;
    int          bp_viol   = 0;
    int          hold_viol = 0;
    int          stall_req = 0;
    int          stall_used = 0;
    bit          hold0     = 1'b0;
    bit          rr_random = 1'b0;
    bit          prev_stalled = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [7:0]    prev_data = 8'd0;

    n1_prog_loader #(
        .RAM_BYTES      (RAM_BYTES),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_ready (ram_ready),
        .core_run  (core_run),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    // RAM side: completed writes plus stability of a stalled write
    always @(posedge clk) begin
        if (rst) begin
            prev_stalled = 1'b0;
        end else begin
            if (prev_stalled && (!ram_we || ram_addr != prev_addr || ram_wdata != prev_data))
                hold_viol++;
            prev_stalled = ram_we && !ram_ready;
            prev_addr    = ram_addr;
            prev_data    = ram_wdata;
            if (ram_we && ram_ready) log_q.push_back({1'b0, ram_addr, ram_wdata});
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst) begin
            if (ram_we && !ram_ready && in_ready) bp_viol++;
            if (core_run && ram_we) bp_viol++;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (hold0) begin
            ram_ready = 1'b0;
        end else if (stall_used < stall_req && ram_we && (log_q.size() - log_base) == 1) begin
            ram_ready = 1'b0;
            stall_used++;
        end else if (rr_random) begin
            ram_ready = ($urandom_range(0, 9) < 7);
        end else begin
            ram_ready = 1'b1;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_data  = b;
        n        = 0;
        acc      = 1'b0;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = in_ready;
            step();
            n++;
        end
        chk("byte_accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_ram_we"},    32'(ram_we),    32'd0);
        chk({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
        chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
        chk({tag, "_core_run"},  32'(core_run),  32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_err"},       32'(err),       32'd0);
        chk({tag, "_err_code"},  32'(err_code),  32'd0);
    endtask

    function automatic logic [7:0] good_csum(input bq_t pl);
        int s = 0;
        foreach (pl[i]) s += int'(pl[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    // Frame-level model: outcome code from length range and byte-sum rule
    function automatic int model_code(input int len, input bq_t pl, input logic [7:0] c);
        int s = int'(c);
        if (len < 1 || len > RAM_BYTES) return 1;
        foreach (pl[i]) s += int'(pl[i]);
        return ((s % 256) == 0) ? 0 : 2;
    endfunction

    task automatic run_check(input string tag, input int len, input bq_t pl,
                             input logic [7:0] c, input int gap_max);
        int code;
        int d0;
        int nexp;
        log_base = log_q.size();
        d0       = done_cnt;
        code     = model_code(len, pl, c);
        send_byte(SYNC);
        idle($urandom_range(0, gap_max));
        send_byte(8'(len));
        if (code != 1) begin
            foreach (pl[i]) begin
                idle($urandom_range(0, gap_max));
                send_byte(pl[i]);
                chk({tag, "_wr_latency"}, {15'd0, ram_we, 1'b0, ram_addr, ram_wdata},
                    {15'd0, 1'b1, 1'b0, 7'(i), pl[i]});
            end
            idle($urandom_range(0, gap_max));
            send_byte(c);
        end
        for (int k = 0; k < 300 && ram_we; k++) step();
        chk({tag, "_drained"}, 32'(ram_we), 32'd0);
        idle(2);
        nexp = (code == 1) ? 0 : len;
        chk({tag, "_err"},      32'(err),      32'(code != 0));
        chk({tag, "_err_code"}, 32'(err_code), 32'(code));
        chk({tag, "_core_run"}, 32'(core_run), 32'(code == 0));
        chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'(code == 0));
        chk({tag, "_nwrites"},  32'(log_q.size() - log_base), 32'(nexp));
        for (int i = 0; i < nexp && (log_base + i) < log_q.size(); i++)
            chk({tag, "_write"}, 32'(log_q[log_base + i]), {16'd0, 1'b0, 7'(i), pl[i]});
    endtask

    initial begin
        bq_t pl;
        logic [7:0] c;
        logic [7:0] b;
        int len;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        idle(2);
        check_reset_vals("reset");
        rst = 1'b0;
        idle(2);

        pl = '{8'h10, 8'h20, 8'h30};
        run_check("basic", 3, pl, 8'hA0, 0);

        stall_req = 5;
        run_check("stall", 3, pl, 8'hA0, 0);
        chk("stall_cycles", 32'(stall_used), 32'd5);

        pl = '{};
        run_check("len_zero", 0, pl, 8'h00, 1);
        run_check("len_129", 129, pl, 8'h00, 1);

        pl = '{8'h01, 8'h02};
        run_check("bad_csum", 2, pl, 8'h00, 1);
        pl = '{8'hFF};
        run_check("len_one", 1, pl, 8'h01, 1);

        log_base = log_q.size();
        send_byte(SYNC);
        send_byte(8'h02);
        send_byte(8'h11);
        idle(TIMEOUT - 1);
        chk("timeout_early_err", 32'(err), 32'd0);
        step();
        chk("timeout_err", 32'(err), 32'd1);
        chk("timeout_code", 32'(err_code), 32'd3);
        chk("timeout_core_run", 32'(core_run), 32'd0);
        chk("timeout_nwrites", 32'(log_q.size() - log_base), 32'd1);
        if (log_q.size() > log_base)
            chk("timeout_write", 32'(log_q[log_base]), 32'h0011);

        log_base = log_q.size();
        hold0    = 1'b1;
        send_byte(SYNC);
        send_byte(8'h04);
        send_byte(8'h55);
        idle(2);
        chk("rst_pending_we", 32'(ram_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        hold0 = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(1);
        chk("rst_dropped_write", 32'(log_q.size() - log_base), 32'd0);
        pl = '{8'h3C, 8'hC3, 8'h77, 8'h08};
        run_check("after_rst", 4, pl, good_csum(pl), 1);

        rr_random = 1'b1;
        pl = '{};
        for (int i = 0; i < RAM_BYTES; i++) pl.push_back(8'($urandom_range(0, 255)));
        run_check("len_max", RAM_BYTES, pl, good_csum(pl), 0);

        for (int f = 0; f < 30; f++) begin
            for (int n = $urandom_range(0, 2); n > 0; n--) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h5A;
                send_byte(b);
            end
            pl = '{};
            if ($urandom_range(0, 9) == 0) begin
                len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(129, 255);
                c   = 8'd0;
            end else begin
                len = $urandom_range(1, 12);
                for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
                c = good_csum(pl);
                if ($urandom_range(0, 3) == 0) c = c + 8'($urandom_range(1, 255));
            end
            run_check("rand", len, pl, c, 3);
        end
        rr_random = 1'b0;
        idle(2);

        chk("backpressure_rules", 32'(bp_viol), 32'd0);
        chk("stalled_write_stable", 32'(hold_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
